// File: rtl/cpuops_pkg.sv
// cpuops_pkg: shared ALU opcode, width and flag definitions for the cpuops arbiter slice.
package cpuops_pkg;
    localparam int DW  = 32;
    localparam int OPW = 4;
    localparam int FW  = 4;
    localparam logic [OPW-1:0] OP_SUB    = 4'h0;
    localparam logic [OPW-1:0] OP_AND    = 4'h1;
    localparam logic [OPW-1:0] OP_ADD    = 4'h2;
    localparam logic [OPW-1:0] OP_OR     = 4'h3;
    localparam logic [OPW-1:0] OP_XOR    = 4'h4;
    localparam logic [OPW-1:0] OP_LSR    = 4'h5;
    localparam logic [OPW-1:0] OP_LSL    = 4'h6;
    localparam logic [OPW-1:0] OP_ASR    = 4'h7;
    localparam logic [OPW-1:0] OP_BREV   = 4'h8;
    localparam logic [OPW-1:0] OP_LDILO  = 4'h9;
    localparam logic [OPW-1:0] OP_MPYUHI = 4'ha;
    localparam logic [OPW-1:0] OP_MPYSHI = 4'hb;
    localparam logic [OPW-1:0] OP_MPY    = 4'hc;
    localparam logic [OPW-1:0] OP_MOV    = 4'hf;
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;
    function automatic logic is_mpy_op(input logic [OPW-1:0] op);
        return op[3:1] == 3'h5 || op == OP_MPY;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first eligible requester at or after ptr, cyclically.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         eligible,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant
);
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   first;
    logic [2*NREQ-1:0] wide;
    // rotate so ptr sits at bit 0, pick the lowest set bit, rotate back
    always_comb begin
        rot = NREQ'({eligible, eligible} >> ptr);
        first = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first = '0;
                first[i] = 1'b1;
            end
        end
        wide = {first, first} << ptr;
        grant = wide[2*NREQ-1:NREQ];
    end
endmodule

// File: rtl/cpuops_arbiter.sv
// cpuops_arbiter: round-robin sharing of one cpuops ALU among NREQ requesters with per-requester response buffers.
module cpuops_arbiter
    import cpuops_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [NREQ-1:0]     i_req_valid,
    output logic [NREQ-1:0]     o_req_ready,
    input  logic [OPW*NREQ-1:0] i_req_op,
    input  logic [DW*NREQ-1:0]  i_req_a,
    input  logic [DW*NREQ-1:0]  i_req_b,
    output logic [NREQ-1:0]     o_rsp_valid,
    input  logic [NREQ-1:0]     i_rsp_ready,
    output logic [DW*NREQ-1:0]  o_rsp_c,
    output logic [FW*NREQ-1:0]  o_rsp_f,
    output logic                o_alu_reset,
    output logic                o_alu_stb,
    output logic [OPW-1:0]      o_alu_op,
    output logic [DW-1:0]       o_alu_a,
    output logic [DW-1:0]       o_alu_b,
    input  logic                i_alu_valid,
    input  logic                i_alu_busy,
    input  logic [DW-1:0]       i_alu_c,
    input  logic [FW-1:0]       i_alu_f,
    output logic                o_err
);
    localparam int IDW = $clog2(NREQ);
    logic                       pending;
    logic [IDW-1:0]             owner;
    logic [IDW-1:0]             rr_ptr;
    logic [IDW-1:0]             gidx;
    logic [NREQ-1:0]            slot_full;
    logic [NREQ-1:0]            slot_wr;
    logic [NREQ-1:0]            elig;
    logic [NREQ-1:0]            grant;
    logic [NREQ-1:0][DW-1:0]    slot_c;
    logic [NREQ-1:0][FW-1:0]    slot_f;
    logic [OPW-1:0]             last_op;
    logic [DW-1:0]              last_a;
    logic [DW-1:0]              last_b;
    logic                       can_issue;
    assign can_issue   = !i_alu_busy && (!pending || i_alu_valid);
    assign o_req_ready = grant;
    assign o_alu_stb   = |grant;
    assign o_alu_reset = !i_reset_n;
    assign o_rsp_valid = slot_full;
    assign o_rsp_c     = slot_c;
    assign o_rsp_f     = slot_f;
    // the owner is blocked while its op is in flight and on the cycle it returns
    always_comb begin
        elig = '0;
        slot_wr = '0;
        for (int k = 0; k < NREQ; k++) begin
            elig[k] = i_req_valid[k] && !(owner == IDW'(k) && (pending || i_alu_valid))
                && (!slot_full[k] || i_rsp_ready[k]) && can_issue && i_reset_n;
            slot_wr[k] = i_alu_valid && pending && owner == IDW'(k);
        end
    end
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .eligible(elig),
        .ptr     (rr_ptr),
        .grant   (grant)
    );
    // idle cycles replay the last issued operands to keep the ALU inputs quiet
    always_comb begin
        gidx = '0;
        o_alu_op = last_op;
        o_alu_a = last_a;
        o_alu_b = last_b;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                gidx = IDW'(k);
                o_alu_op = i_req_op[OPW*k +: OPW];
                o_alu_a = i_req_a[DW*k +: DW];
                o_alu_b = i_req_b[DW*k +: DW];
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pending <= 1'b0;
            owner <= '0;
            rr_ptr <= '0;
            slot_full <= '0;
            o_err <= 1'b0;
            last_op <= '0;
            last_a <= '0;
            last_b <= '0;
        end else begin
            if (o_alu_stb) begin
                pending <= 1'b1;
                owner <= gidx;
                rr_ptr <= gidx == IDW'(NREQ - 1) ? '0 : gidx + 1'b1;
                last_op <= o_alu_op;
                last_a <= o_alu_a;
                last_b <= o_alu_b;
            end else if (i_alu_valid) begin
                pending <= 1'b0;
            end
            if (i_alu_valid && (!pending || i_alu_busy))
                o_err <= 1'b1;
            for (int k = 0; k < NREQ; k++)
                slot_full[k] <= slot_wr[k] || (slot_full[k] && !i_rsp_ready[k]);
        end
    end
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (slot_wr[k]) begin
                slot_c[k] <= i_alu_c;
                slot_f[k] <= i_alu_f;
            end
        end
    end
endmodule

// File: tb/tb_cpuops_arbiter.sv
// tb_cpuops_arbiter: directed tests of the cpuops arbiter against a small behavioural ALU.
module tb_cpuops_arbiter;
    import cpuops_pkg::*;
    logic        i_clk;
    logic        i_reset_n;
    logic [1:0]  i_req_valid;
    logic [1:0]  o_req_ready;
    logic [7:0]  i_req_op;
    logic [63:0] i_req_a;
    logic [63:0] i_req_b;
    logic [1:0]  o_rsp_valid;
    logic [1:0]  i_rsp_ready;
    logic [63:0] o_rsp_c;
    logic [7:0]  o_rsp_f;
    logic        o_alu_reset;
    logic        o_alu_stb;
    logic [3:0]  o_alu_op;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic        i_alu_valid;
    logic        i_alu_busy;
    logic [31:0] i_alu_c;
    logic [3:0]  i_alu_f;
    logic        o_err;
    int          checks;
    int          errors;
    int          busy_cnt;
    bit          alu_auto;
    logic [35:0] m_res;

    cpuops_arbiter #(.NREQ(2)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_op   (i_req_op),
        .i_req_a    (i_req_a),
        .i_req_b    (i_req_b),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_c    (o_rsp_c),
        .o_rsp_f    (o_rsp_f),
        .o_alu_reset(o_alu_reset),
        .o_alu_stb  (o_alu_stb),
        .o_alu_op   (o_alu_op),
        .o_alu_a    (o_alu_a),
        .o_alu_b    (o_alu_b),
        .i_alu_valid(i_alu_valid),
        .i_alu_busy (i_alu_busy),
        .i_alu_c    (i_alu_c),
        .i_alu_f    (i_alu_f),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [35:0] alu_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] c;
        logic        v;
        logic        cy;
        v = 1'b0;
        cy = 1'b0;
        s = '0;
        if (op == OP_SUB) begin
            s = {1'b0, a} - {1'b0, b};
            c = s[31:0];
            cy = s[32];
            v = (a[31] != b[31]) && (c[31] != a[31]);
        end else if (op == OP_ADD) begin
            s = {1'b0, a} + {1'b0, b};
            c = s[31:0];
            cy = s[32];
            v = (a[31] == b[31]) && (c[31] != a[31]);
        end else if (op == OP_MPY) begin
            c = a * b;
        end else begin
            c = b;
        end
        return {v, c[31], cy, c == 32'd0, c};
    endfunction

    // one clock; the ALU model reacts to what was issued before the edge
    task automatic cycle();
        logic        stb;
        logic        rst;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        stb = o_alu_stb;
        rst = o_alu_reset;
        op = o_alu_op;
        a = o_alu_a;
        b = o_alu_b;
        @(posedge i_clk);
        #1;
        if (alu_auto) begin
            i_alu_valid = 1'b0;
            if (rst) begin
                busy_cnt = 0;
                i_alu_busy = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    i_alu_busy = 1'b0;
                    i_alu_valid = 1'b1;
                    i_alu_c = m_res[31:0];
                    i_alu_f = m_res[35:32];
                end
            end else if (stb) begin
                m_res = alu_eval(op, a, b);
                if (op == OP_MPY) begin
                    busy_cnt = 3;
                    i_alu_busy = 1'b1;
                end else begin
                    i_alu_valid = 1'b1;
                    i_alu_c = m_res[31:0];
                    i_alu_f = m_res[35:32];
                end
            end
        end
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_req_valid = 2'b00;
        i_rsp_ready = 2'b00;
        alu_auto = 1'b1;
        i_alu_valid = 1'b0;
        i_alu_busy = 1'b0;
        busy_cnt = 0;
        cycle();
        cycle();
        i_reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_req_op = {OP_ADD, OP_ADD};
        i_req_valid = 2'b11;
        cycle();
        cycle();
        checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", o_req_ready); end
        checks++; if (o_alu_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", o_alu_stb); end
        checks++; if (o_alu_reset !== 1'b1) begin errors++; $display("FAIL reset_alu_reset: got %b want 1", o_alu_reset); end
        checks++; if (o_rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", o_rsp_valid); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_err); end
        i_req_valid = 2'b00;
        i_reset_n = 1'b1;
        #1;
        checks++; if (o_alu_reset !== 1'b0) begin errors++; $display("FAIL release_alu_reset: got %b want 0", o_alu_reset); end
    endtask

    task automatic test_single_sub();
        do_reset();
        i_req_op[3:0] = OP_SUB;
        i_req_a[31:0] = 32'd5;
        i_req_b[31:0] = 32'd7;
        i_req_valid = 2'b01;
        #1;
        checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL sub_grant: got %b want 01", o_req_ready); end
        checks++; if ({o_alu_stb, o_alu_op, o_alu_a, o_alu_b} !== {1'b1, OP_SUB, 32'd5, 32'd7}) begin errors++; $display("FAIL sub_issue: got %b %h %h %h want 1 0 5 7", o_alu_stb, o_alu_op, o_alu_a, o_alu_b); end
        cycle();
        i_req_valid = 2'b00;
        #1;
        checks++; if (o_rsp_valid !== 2'b00) begin errors++; $display("FAIL sub_rsp_early: got %b want 00", o_rsp_valid); end
        cycle();
        checks++; if (o_rsp_valid !== 2'b01) begin errors++; $display("FAIL sub_rsp_valid: got %b want 01", o_rsp_valid); end
        checks++; if (o_rsp_c[31:0] !== 32'hfffffffe) begin errors++; $display("FAIL sub_rsp_c: got %h want fffffffe", o_rsp_c[31:0]); end
        checks++; if (o_rsp_f[3:0] !== 4'b0110) begin errors++; $display("FAIL sub_rsp_f: got %b want 0110", o_rsp_f[3:0]); end
        i_rsp_ready = 2'b01;
        cycle();
        checks++; if (o_rsp_valid !== 2'b00) begin errors++; $display("FAIL sub_drain: got %b want 00", o_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_rsp_ready = 2'b11;
        i_req_op = {OP_ADD, OP_ADD};
        i_req_a = {32'd100, 32'd10};
        i_req_b = {32'd200, 32'd1};
        i_req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (o_req_ready !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_grant[%0d]: got %b", i, o_req_ready); end
            if (i >= 2) begin
                checks++; if (o_rsp_valid !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_rsp_valid[%0d]: got %b", i, o_rsp_valid); end
                checks++; if ((i % 2 == 0 ? o_rsp_c[31:0] : o_rsp_c[63:32]) !== (i % 2 == 0 ? 32'd11 : 32'd300)) begin errors++; $display("FAIL alt_rsp_c[%0d]: got %h", i, o_rsp_c); end
            end
            cycle();
        end
        i_req_valid = 2'b00;
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_mpy_busy();
        do_reset();
        i_req_op[7:4] = OP_MPY;
        i_req_a[63:32] = 32'd3;
        i_req_b[63:32] = 32'd4;
        i_req_valid = 2'b10;
        #1;
        checks++; if (o_req_ready !== 2'b10) begin errors++; $display("FAIL mpy_grant: got %b want 10", o_req_ready); end
        cycle();
        i_req_op[3:0] = OP_ADD;
        i_req_a[31:0] = 32'd1;
        i_req_b[31:0] = 32'd2;
        i_req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL mpy_busy_grant[%0d]: got %b want 00", i, o_req_ready); end
            cycle();
        end
        #1;
        checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL mpy_return_grant: got %b want 01", o_req_ready); end
        cycle();
        i_req_valid = 2'b00;
        #1;
        checks++; if (o_rsp_valid !== 2'b10) begin errors++; $display("FAIL mpy_rsp_valid: got %b want 10", o_rsp_valid); end
        checks++; if (o_rsp_c[63:32] !== 32'd12) begin errors++; $display("FAIL mpy_rsp_c: got %h want c", o_rsp_c[63:32]); end
        cycle();
        checks++; if (o_rsp_valid !== 2'b11) begin errors++; $display("FAIL mpy_add_rsp_valid: got %b want 11", o_rsp_valid); end
        checks++; if (o_rsp_c[31:0] !== 32'd3) begin errors++; $display("FAIL mpy_add_rsp_c: got %h want 3", o_rsp_c[31:0]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_req_op = {OP_ADD, OP_ADD};
        i_req_a = {32'd2, 32'd1};
        i_req_b = {32'd2, 32'd1};
        i_req_valid = 2'b01;
        #1;
        checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_grant: got %b want 01", o_req_ready); end
        cycle();
        i_req_valid = 2'b11;
        i_rsp_ready = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (o_req_ready !== (i % 2 == 0 ? 2'b10 : 2'b00)) begin errors++; $display("FAIL bp_grant[%0d]: got %b", i, o_req_ready); end
            cycle();
        end
        checks++; if (o_rsp_valid[0] !== 1'b1 || o_rsp_c[31:0] !== 32'd2) begin errors++; $display("FAIL bp_held: got %b %h want 1 2", o_rsp_valid[0], o_rsp_c[31:0]); end
        i_rsp_ready = 2'b11;
        #1;
        checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_grant: got %b want 01", o_req_ready); end
        cycle();
        i_req_valid = 2'b00;
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        i_rsp_ready = 2'b11;
        i_req_op = {OP_MPY, OP_SUB};
        i_req_a = {32'd3, 32'd9};
        i_req_b = {32'd4, 32'd2};
        i_req_valid = 2'b10;
        #1;
        checks++; if (o_req_ready !== 2'b10) begin errors++; $display("FAIL rst_mpy_grant: got %b want 10", o_req_ready); end
        cycle();
        i_req_valid = 2'b01;
        cycle();
        i_reset_n = 1'b0;
        cycle();
        checks++; if (o_rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", o_rsp_valid); end
        checks++; if (o_alu_reset !== 1'b1) begin errors++; $display("FAIL rst_alu_reset: got %b want 1", o_alu_reset); end
        checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", o_req_ready); end
        cycle();
        i_reset_n = 1'b1;
        #1;
        checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL rst_after_grant: got %b want 01", o_req_ready); end
        cycle();
        i_req_valid = 2'b00;
        i_rsp_ready = 2'b00;
        cycle();
        checks++; if (o_rsp_valid !== 2'b01) begin errors++; $display("FAIL rst_after_rsp_valid: got %b want 01", o_rsp_valid); end
        checks++; if ({o_rsp_f[3:0], o_rsp_c[31:0]} !== {4'b0000, 32'd7}) begin errors++; $display("FAIL rst_after_rsp: got %b %h want 0000 7", o_rsp_f[3:0], o_rsp_c[31:0]); end
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (o_rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL rst_stale: got %b want 0", o_rsp_valid[1]); end
    endtask

    task automatic test_err();
        do_reset();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", o_err); end
        alu_auto = 1'b0;
        i_alu_valid = 1'b1;
        i_alu_c = 32'hdeadbeef;
        i_alu_f = 4'hf;
        cycle();
        i_alu_valid = 1'b0;
        #1;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", o_err); end
        checks++; if (o_rsp_valid !== 2'b00) begin errors++; $display("FAIL err_no_write: got %b want 00", o_rsp_valid); end
        cycle();
        cycle();
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", o_err); end
        do_reset();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", o_err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        busy_cnt = 0;
        alu_auto = 1'b1;
        m_res = '0;
        i_reset_n = 1'b0;
        i_req_valid = 2'b00;
        i_req_op = '0;
        i_req_a = '0;
        i_req_b = '0;
        i_rsp_ready = 2'b00;
        i_alu_valid = 1'b0;
        i_alu_busy = 1'b0;
        i_alu_c = '0;
        i_alu_f = '0;
        test_reset();
        test_single_sub();
        test_back_to_back();
        test_mpy_busy();
        test_backpressure();
        test_reset_inflight();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
